// File: rtl/scarv_axi_sram_pkg.sv
// Shared definitions for the AXI4-lite SRAM slave: response codes, state
// encodings and the address-window test.
package scarv_axi_sram_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_W_DATA = 3'd1;
  localparam logic [2:0] ST_W_MEM  = 3'd2;
  localparam logic [2:0] ST_W_RESP = 3'd3;
  localparam logic [2:0] ST_R_MEM  = 3'd4;
  localparam logic [2:0] ST_R_CAP  = 3'd5;
  localparam logic [2:0] ST_R_RESP = 3'd6;

  // Offset is taken modulo 2^32, so addresses below the base wrap high and miss.
  function automatic logic addr_in_window(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [32:0] span);
    logic [31:0] off;
    off = addr - base;
    return ({1'b0, off} < span);
  endfunction

endpackage

// File: rtl/scarv_axi_sram.sv
// AXI4-lite slave in front of a single-port byte-enabled synchronous SRAM.
// One transaction at a time; writes win over reads; out-of-window gives SLVERR.
module scarv_axi_sram
  import scarv_axi_sram_pkg::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  localparam int         AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          s_axi_awvalid,
  output logic          s_axi_awready,
  input  logic [31:0]   s_axi_awaddr,
  input  logic [2:0]    s_axi_awprot,
  input  logic          s_axi_wvalid,
  output logic          s_axi_wready,
  input  logic [31:0]   s_axi_wdata,
  input  logic [3:0]    s_axi_wstrb,
  output logic          s_axi_bvalid,
  input  logic          s_axi_bready,
  output logic [1:0]    s_axi_bresp,
  input  logic          s_axi_arvalid,
  output logic          s_axi_arready,
  input  logic [31:0]   s_axi_araddr,
  input  logic [2:0]    s_axi_arprot,
  output logic          s_axi_rvalid,
  input  logic          s_axi_rready,
  output logic [31:0]   s_axi_rdata,
  output logic [1:0]    s_axi_rresp,
  output logic          sram_cs,
  output logic [3:0]    sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata
);

  localparam logic [32:0] WIN_BYTES = 33'(MEM_WORDS) << 2;

  logic [2:0]    state_q, state_d;
  logic          in_range_q, in_range_d;
  logic          bvalid_q, bvalid_d;
  logic [1:0]    bresp_q, bresp_d;
  logic          rvalid_q, rvalid_d;
  logic [1:0]    rresp_q, rresp_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          sram_cs_q, sram_cs_d;
  logic [3:0]    sram_we_q, sram_we_d;
  logic [AW-1:0] sram_addr_q, sram_addr_d;
  logic [31:0]   sram_wdata_q, sram_wdata_d;

  logic aw_in_range_s;
  logic ar_in_range_s;
  logic unused_prot_s;

  assign aw_in_range_s = addr_in_window(s_axi_awaddr, BASE_ADDR, WIN_BYTES);
  assign ar_in_range_s = addr_in_window(s_axi_araddr, BASE_ADDR, WIN_BYTES);
  assign unused_prot_s = ^{s_axi_awprot, s_axi_arprot};

  assign s_axi_awready = (state_q == ST_IDLE);
  assign s_axi_wready  = ((state_q == ST_IDLE) && s_axi_awvalid) || (state_q == ST_W_DATA);
  assign s_axi_arready = (state_q == ST_IDLE) && !s_axi_awvalid;

  // SRAM controls are loaded on entry to the access state so they are flop outputs.
  always_comb begin
    state_d      = state_q;
    in_range_d   = in_range_q;
    bvalid_d     = bvalid_q;
    bresp_d      = bresp_q;
    rvalid_d     = rvalid_q;
    rresp_d      = rresp_q;
    rdata_d      = rdata_q;
    sram_cs_d    = 1'b0;
    sram_we_d    = 4'h0;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (s_axi_awvalid) begin
          in_range_d  = aw_in_range_s;
          sram_addr_d = s_axi_awaddr[AW+1:2];
          if (s_axi_wvalid) begin
            state_d      = ST_W_MEM;
            sram_cs_d    = aw_in_range_s;
            sram_we_d    = aw_in_range_s ? s_axi_wstrb : 4'h0;
            sram_wdata_d = s_axi_wdata;
          end else begin
            state_d = ST_W_DATA;
          end
        end else if (s_axi_arvalid) begin
          state_d     = ST_R_MEM;
          in_range_d  = ar_in_range_s;
          sram_addr_d = s_axi_araddr[AW+1:2];
          sram_cs_d   = ar_in_range_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_W_DATA: begin
        if (s_axi_wvalid) begin
          state_d      = ST_W_MEM;
          sram_cs_d    = in_range_q;
          sram_we_d    = in_range_q ? s_axi_wstrb : 4'h0;
          sram_wdata_d = s_axi_wdata;
        end else begin
          state_d = ST_W_DATA;
        end
      end
      ST_W_MEM: begin
        state_d  = ST_W_RESP;
        bvalid_d = 1'b1;
        bresp_d  = in_range_q ? RESP_OKAY : RESP_SLVERR;
      end
      ST_W_RESP: begin
        if (s_axi_bready) begin
          state_d  = ST_IDLE;
          bvalid_d = 1'b0;
        end else begin
          bvalid_d = 1'b1;
        end
      end
      ST_R_MEM: begin
        state_d = ST_R_CAP;
      end
      ST_R_CAP: begin
        state_d  = ST_R_RESP;
        rvalid_d = 1'b1;
        rdata_d  = in_range_q ? sram_rdata : 32'h0000_0000;
        rresp_d  = in_range_q ? RESP_OKAY : RESP_SLVERR;
      end
      ST_R_RESP: begin
        if (s_axi_rready) begin
          state_d  = ST_IDLE;
          rvalid_d = 1'b0;
        end else begin
          rvalid_d = 1'b1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        bvalid_d = 1'b0;
        rvalid_d = 1'b0;
      end
    endcase
  end

  // State and all registered outputs; reset drops any access or response at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      in_range_q   <= 1'b0;
      bvalid_q     <= 1'b0;
      bresp_q      <= 2'b00;
      rvalid_q     <= 1'b0;
      rresp_q      <= 2'b00;
      rdata_q      <= 32'h0000_0000;
      sram_cs_q    <= 1'b0;
      sram_we_q    <= 4'h0;
      sram_addr_q  <= '0;
      sram_wdata_q <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      in_range_q   <= in_range_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      rvalid_q     <= rvalid_d;
      rresp_q      <= rresp_d;
      rdata_q      <= rdata_d;
      sram_cs_q    <= sram_cs_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
    end
  end

  assign s_axi_bvalid = bvalid_q;
  assign s_axi_bresp  = bresp_q;
  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rresp  = rresp_q;
  assign s_axi_rdata  = rdata_q;
  assign sram_cs      = sram_cs_q;
  assign sram_we      = sram_we_q;
  assign sram_addr    = sram_addr_q;
  assign sram_wdata   = sram_wdata_q;

endmodule

// File: tb/tb_scarv_axi_sram.sv
// Bench for scarv_axi_sram: transaction-level memory model, a behavioural SRAM,
// and one per-cycle compare process, plus directed latency/literal checks.
module tb_scarv_axi_sram;

  localparam int          MW    = 256;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          AWB   = $clog2(MW);
  localparam int          BOUND = 40;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           s_axi_awvalid = 1'b0;
  logic           s_axi_awready;
  logic [31:0]    s_axi_awaddr = 32'h0;
  logic [2:0]     s_axi_awprot = 3'b000;
  logic           s_axi_wvalid = 1'b0;
  logic           s_axi_wready;
  logic [31:0]    s_axi_wdata = 32'h0;
  logic [3:0]     s_axi_wstrb = 4'h0;
  logic           s_axi_bvalid;
  logic           s_axi_bready = 1'b0;
  logic [1:0]     s_axi_bresp;
  logic           s_axi_arvalid = 1'b0;
  logic           s_axi_arready;
  logic [31:0]    s_axi_araddr = 32'h0;
  logic [2:0]     s_axi_arprot = 3'b000;
  logic           s_axi_rvalid;
  logic           s_axi_rready = 1'b0;
  logic [31:0]    s_axi_rdata;
  logic [1:0]     s_axi_rresp;
  logic           sram_cs;
  logic [3:0]     sram_we;
  logic [AWB-1:0] sram_addr;
  logic [31:0]    sram_wdata;
  logic [31:0]    sram_rdata = 32'h0;

  scarv_axi_sram #(.MEM_WORDS(MW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .resetn(resetn),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [AWB-1:0] addr; logic [3:0] we; logic [31:0] wdata; } acc_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; } rsp_t;

  acc_t        exp_acc[$];
  rsp_t        exp_r[$];
  logic [1:0]  exp_b[$];
  logic [31:0] ref_mem [MW];
  logic [31:0] sram_mem [MW];
  int n_chk = 0;
  int n_pass = 0;
  int cs_cyc = -1;

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic bit in_win(input logic [31:0] a);
    return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + longint'(MW) * 4);
  endfunction

  // Expected effect of one write: memory merge, SRAM access, B response.
  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int w;
    if (in_win(a)) begin
      w = int'((a - BASE) >> 2);
      exp_acc.push_back('{AWB'(w), s, d});
      for (int b = 0; b < 4; b++) if (s[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
      exp_b.push_back(2'b00);
    end else begin
      exp_b.push_back(2'b10);
    end
  endtask

  task automatic model_read(input logic [31:0] a);
    int w;
    if (in_win(a)) begin
      w = int'((a - BASE) >> 2);
      exp_acc.push_back('{AWB'(w), 4'h0, 32'h0});
      exp_r.push_back('{ref_mem[w], 2'b00});
    end else begin
      exp_r.push_back('{32'h0, 2'b10});
    end
  endtask

  // Behavioural SRAM: byte-enabled writes, read data one cycle after select.
  logic mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < MW; i++) sram_mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else if (sram_cs) begin
      if (sram_we == 4'h0) sram_rdata <= sram_mem[sram_addr];
      else for (int b = 0; b < 4; b++)
        if (sram_we[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
  end

  acc_t        cmp_acc;
  rsp_t        cmp_r;
  logic [1:0]  cmp_b;
  logic        prev_rv = 1'b0, prev_rr = 1'b0, prev_bv = 1'b0, prev_br = 1'b0;
  logic [31:0] prev_rd = 32'h0;
  logic [1:0]  prev_rs = 2'b00, prev_bs = 2'b00;

  // Per-cycle compare against the model queues, plus response-hold rules.
  always @(negedge clk) begin
    if (!resetn) begin
      prev_rv = 1'b0;
      prev_bv = 1'b0;
    end else begin
      if (sram_cs) begin
        cs_cyc = cyc;
        if (exp_acc.size() == 0) chk("unexpected_sram_cs", 32'd1, 32'd0);
        else begin
          cmp_acc = exp_acc.pop_front();
          chk("sram_addr", 32'(sram_addr), 32'(cmp_acc.addr));
          chk("sram_we", 32'(sram_we), 32'(cmp_acc.we));
          if (cmp_acc.we != 4'h0) chk("sram_wdata", sram_wdata, cmp_acc.wdata);
        end
      end
      if (prev_rv && !prev_rr) begin
        chk("rvalid_hold", 32'(s_axi_rvalid), 32'd1);
        chk("rdata_hold", s_axi_rdata, prev_rd);
        chk("rresp_hold", 32'(s_axi_rresp), 32'(prev_rs));
      end
      if (prev_bv && !prev_br) begin
        chk("bvalid_hold", 32'(s_axi_bvalid), 32'd1);
        chk("bresp_hold", 32'(s_axi_bresp), 32'(prev_bs));
      end
      if (s_axi_rvalid && s_axi_rready) begin
        if (exp_r.size() == 0) chk("unexpected_r", 32'd1, 32'd0);
        else begin
          cmp_r = exp_r.pop_front();
          chk("rdata", s_axi_rdata, cmp_r.data);
          chk("rresp", 32'(s_axi_rresp), 32'(cmp_r.resp));
        end
      end
      if (s_axi_bvalid && s_axi_bready) begin
        if (exp_b.size() == 0) chk("unexpected_b", 32'd1, 32'd0);
        else begin
          cmp_b = exp_b.pop_front();
          chk("bresp", 32'(s_axi_bresp), 32'(cmp_b));
        end
      end
      prev_rv = s_axi_rvalid; prev_rr = s_axi_rready; prev_rd = s_axi_rdata; prev_rs = s_axi_rresp;
      prev_bv = s_axi_bvalid; prev_br = s_axi_bready; prev_bs = s_axi_bresp;
    end
  end

  task automatic send_aw(input logic [31:0] a, output int hs);
    s_axi_awaddr = a; s_axi_awvalid = 1'b1; hs = -1;
    for (int n = 0; n < BOUND; n++) begin
      #1; if (s_axi_awready) hs = cyc;
      @(posedge clk); #2;
      if (hs >= 0) break;
    end
    s_axi_awvalid = 1'b0;
    if (hs < 0) chk("aw_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_ar(input logic [31:0] a, output int hs);
    s_axi_araddr = a; s_axi_arvalid = 1'b1; hs = -1;
    for (int n = 0; n < BOUND; n++) begin
      #1; if (s_axi_arready) hs = cyc;
      @(posedge clk); #2;
      if (hs >= 0) break;
    end
    s_axi_arvalid = 1'b0;
    if (hs < 0) chk("ar_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int delay, output int hs);
    repeat (delay) begin
      #1; chk("wready_wait", 32'(s_axi_wready), 32'd1);
      @(posedge clk); #2;
    end
    s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1; hs = -1;
    for (int n = 0; n < BOUND; n++) begin
      #1; if (s_axi_wready) hs = cyc;
      @(posedge clk); #2;
      if (hs >= 0) break;
    end
    s_axi_wvalid = 1'b0;
    if (hs < 0) chk("w_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid(input bit rd, output int vcyc);
    vcyc = -1;
    for (int n = 0; n < BOUND; n++) begin
      #1;
      if ((rd ? s_axi_rvalid : s_axi_bvalid) == 1'b1) begin vcyc = cyc; break; end
      @(posedge clk); #2;
    end
    if (vcyc < 0) begin
      if (rd) chk("rvalid_timeout", 32'd0, 32'd1);
      else chk("bvalid_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic recv_b(input int hold, output int vcyc, output int hs, output logic [1:0] resp);
    hs = -1; resp = 2'b11;
    wait_valid(1'b0, vcyc);
    if (vcyc < 0) return;
    repeat (hold) begin @(posedge clk); #3; end
    s_axi_bready = 1'b1; resp = s_axi_bresp; hs = cyc;
    @(posedge clk); #2;
    s_axi_bready = 1'b0;
  endtask

  task automatic recv_r(input int hold, output int vcyc, output logic [31:0] d, output logic [1:0] rs);
    d = 32'hxxxx_xxxx; rs = 2'b11;
    wait_valid(1'b1, vcyc);
    if (vcyc < 0) return;
    repeat (hold) begin @(posedge clk); #3; end
    s_axi_rready = 1'b1; d = s_axi_rdata; rs = s_axi_rresp;
    @(posedge clk); #2;
    s_axi_rready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int delay, output int aw_hs, output int w_hs,
                          output int bv, output logic [1:0] resp);
    int bhs;
    model_write(a, d, s);
    fork
      send_aw(a, aw_hs);
      send_w(d, s, delay, w_hs);
    join
    recv_b(0, bv, bhs, resp);
  endtask

  task automatic do_read(input logic [31:0] a, input int hold, output int ar_hs,
                         output int rv, output logic [31:0] d, output logic [1:0] rs);
    model_read(a);
    send_ar(a, ar_hs);
    recv_r(hold, rv, d, rs);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int aw_hs, w_hs, bv, b_hs, ar_hs, rv, c0;
    logic [31:0] d;
    logic [1:0]  rs, bs;
    for (int i = 0; i < MW; i++) ref_mem[i] = init_word(i);

    repeat (3) @(posedge clk);
    #3;
    chk("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    chk("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
    chk("rst_bresp", 32'(s_axi_bresp), 32'd0);
    chk("rst_rresp", 32'(s_axi_rresp), 32'd0);
    chk("rst_rdata", s_axi_rdata, 32'd0);
    chk("rst_sram_cs", 32'(sram_cs), 32'd0);
    chk("rst_sram_we", 32'(sram_we), 32'd0);
    chk("rst_sram_addr", 32'(sram_addr), 32'd0);
    chk("rst_sram_wdata", sram_wdata, 32'd0);
    chk("rst_awready", 32'(s_axi_awready), 32'd1);
    chk("rst_arready", 32'(s_axi_arready), 32'd1);
    chk("rst_wready", 32'(s_axi_wready), 32'd0);
    resetn = 1'b1;
    @(posedge clk); #2;

    // Full write with AW+W together, then read it back.
    do_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, aw_hs, w_hs, bv, bs);
    chk("wr1_bresp", 32'(bs), 32'd0);
    chk("wr1_w_same_cycle", 32'(w_hs), 32'(aw_hs));
    chk("wr1_sram_cycle", 32'(cs_cyc), 32'(aw_hs + 1));
    chk("wr1_bvalid_lat", 32'(bv), 32'(aw_hs + 2));
    do_read(BASE + 32'h10, 0, ar_hs, rv, d, rs);
    chk("rd1_data", d, 32'hDEAD_BEEF);
    chk("rd1_resp", 32'(rs), 32'd0);
    chk("rd1_sram_cycle", 32'(cs_cyc), 32'(ar_hs + 1));
    chk("rd1_rvalid_lat", 32'(rv), 32'(ar_hs + 3));

    // Single byte lane merge.
    do_write(BASE + 32'h20, 32'h1122_3344, 4'hF, 0, aw_hs, w_hs, bv, bs);
    do_write(BASE + 32'h20, 32'h0000_00AA, 4'b0001, 0, aw_hs, w_hs, bv, bs);
    do_read(BASE + 32'h20, 0, ar_hs, rv, d, rs);
    chk("rd_byte_merge", d, 32'h1122_33AA);

    // W arrives three cycles after AW.
    do_write(BASE + 32'h30, 32'hCAFE_F00D, 4'hF, 3, aw_hs, w_hs, bv, bs);
    chk("wlag_w_cycle", 32'(w_hs), 32'(aw_hs + 3));
    chk("wlag_sram_cycle", 32'(cs_cyc), 32'(aw_hs + 4));
    chk("wlag_bvalid_lat", 32'(bv), 32'(aw_hs + 5));

    // AW and AR together: write first, AR accepted right after B handshake.
    model_write(BASE + 32'h40, 32'h5A5A_1234, 4'hF);
    model_read(BASE + 32'h40);
    fork
      send_aw(BASE + 32'h40, aw_hs);
      send_w(32'h5A5A_1234, 4'hF, 0, w_hs);
      send_ar(BASE + 32'h40, ar_hs);
      recv_b(0, bv, b_hs, bs);
    join
    chk("coll_b_first", 32'(bv), 32'(aw_hs + 2));
    chk("coll_ar_after_b", 32'(ar_hs), 32'(b_hs + 1));
    recv_r(0, rv, d, rs);
    chk("coll_rdata", d, 32'h5A5A_1234);

    // Out-of-window accesses.
    do_read(BASE + 32'h400, 0, ar_hs, rv, d, rs);
    chk("oor_rdata", d, 32'h0);
    chk("oor_rresp", 32'(rs), 32'd2);
    do_write(BASE - 32'h4, 32'hFFFF_FFFF, 4'hF, 0, aw_hs, w_hs, bv, bs);
    chk("oor_below_bresp", 32'(bs), 32'd2);
    do_write(BASE + 32'h410, 32'h0BAD_0BAD, 4'hF, 0, aw_hs, w_hs, bv, bs);
    chk("oor_above_bresp", 32'(bs), 32'd2);
    do_read(BASE + 32'h10, 0, ar_hs, rv, d, rs);
    chk("oor_mem_unchanged", d, 32'hDEAD_BEEF);

    // Zero-strobe write is an OKAY no-op.
    do_write(BASE + 32'h20, 32'hFFFF_FFFF, 4'h0, 0, aw_hs, w_hs, bv, bs);
    chk("noop_bresp", 32'(bs), 32'd0);
    do_read(BASE + 32'h20, 0, ar_hs, rv, d, rs);
    chk("noop_unchanged", d, 32'h1122_33AA);

    // Read response held while rready stays low.
    do_write(BASE + 32'h50, 32'h1234_5678, 4'hF, 0, aw_hs, w_hs, bv, bs);
    do_read(BASE + 32'h50, 5, ar_hs, rv, d, rs);
    chk("hold_rdata", d, 32'h1234_5678);
    chk("hold_rvalid_lat", 32'(rv), 32'(ar_hs + 3));

    // Back-to-back writes: next AW accepted the cycle after the B handshake.
    do_write(BASE + 32'h60, 32'h600D_F00D, 4'hF, 0, aw_hs, w_hs, bv, bs);
    c0 = cyc;
    do_write(BASE + 32'h64, 32'h0000_0064, 4'hF, 0, aw_hs, w_hs, bv, bs);
    chk("b2b_aw_cycle", 32'(aw_hs), 32'(c0));

    // Reset while a read response is pending.
    model_read(BASE + 32'h50);
    send_ar(BASE + 32'h50, ar_hs);
    wait_valid(1'b1, rv);
    resetn = 1'b0;
    #1;
    chk("rstmid_rvalid", 32'(s_axi_rvalid), 32'd0);
    chk("rstmid_rdata", s_axi_rdata, 32'd0);
    chk("rstmid_awready", 32'(s_axi_awready), 32'd1);
    chk("rstmid_arready", 32'(s_axi_arready), 32'd1);
    exp_r.delete();
    @(posedge clk); @(posedge clk); #2;
    resetn = 1'b1;
    @(posedge clk); #2;

    // Reset after AW but before W: the write never reaches the SRAM.
    send_aw(BASE + 32'h70, aw_hs);
    #1;
    resetn = 1'b0;
    #1;
    chk("abort_sram_cs", 32'(sram_cs), 32'd0);
    @(posedge clk); @(posedge clk); #2;
    resetn = 1'b1;
    @(posedge clk); #2;
    do_read(BASE + 32'h70, 0, ar_hs, rv, d, rs);
    chk("abort_mem_unchanged", d, 32'hC0DE_001C);

    repeat (3) begin @(posedge clk); #2; end
    chk("drain_acc", 32'(exp_acc.size()), 32'd0);
    chk("drain_r", 32'(exp_r.size()), 32'd0);
    chk("drain_b", 32'(exp_b.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
